// File: rtl/tt_um_usman_serial_adder.sv
// Bit-serial adder tile: one shared 1-bit half adder, used twice per bit (HA1: a^b, HA2: s1^carry),
// sequences WIDTH operand bits and latches {carry_out, sum} on completion.
module tt_um_usman_serial_adder #(
    parameter int unsigned WIDTH = 4
) (
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe,
    input  logic       ena,
    input  logic       clk,
    input  logic       rst_n
);

    typedef enum logic [1:0] {StIdle, StHa1, StHa2} state_e;

    // Drops operand bits at or above WIDTH on capture.
    localparam logic [3:0] OpMask = ~(4'hF << WIDTH);

    state_e     r_state;
    state_e     w_state_next;
    logic       r_start_q;
    logic [3:0] r_a;
    logic [3:0] r_b;
    logic [3:0] r_sum;
    logic [3:0] r_idx_oh;
    logic       r_carry;
    logic       r_s1;
    logic       r_c1;
    logic [4:0] r_result;
    logic       r_done;

    logic       w_start_pulse;
    logic       w_ha_a;
    logic       w_ha_b;
    logic       w_ha_s;
    logic       w_ha_c;
    logic       w_carry_new;
    logic       w_last;
    logic [3:0] w_sum_next;
    logic [4:0] w_result_next;
    logic       w_busy;
    logic       w_phase;
    logic       w_unused;

    assign w_start_pulse = uio_in[0] & ~r_start_q;
    assign w_last        = r_idx_oh[WIDTH-1];

    // The single half adder; its inputs are the only thing that changes between phases.
    always_comb begin
        w_ha_a = 1'b0;
        w_ha_b = 1'b0;
        unique case (r_state)
            StHa1: begin
                w_ha_a = |(r_a & r_idx_oh);
                w_ha_b = |(r_b & r_idx_oh);
            end
            StHa2: begin
                w_ha_a = r_s1;
                w_ha_b = r_carry;
            end
            default: ;
        endcase
    end

    assign w_ha_s      = w_ha_a ^ w_ha_b;
    assign w_ha_c      = w_ha_a & w_ha_b;
    assign w_carry_new = r_c1 | w_ha_c;
    assign w_sum_next  = w_ha_s ? (r_sum | r_idx_oh) : r_sum;

    always_comb begin
        w_result_next             = '0;
        w_result_next[WIDTH-1:0]  = w_sum_next[WIDTH-1:0];
        w_result_next[WIDTH]      = w_carry_new;
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle:  if (w_start_pulse) w_state_next = StHa1;
            StHa1:   w_state_next = StHa2;
            StHa2:   w_state_next = w_last ? StIdle : StHa1;
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= StIdle;
            r_start_q <= 1'b0;
            r_a       <= '0;
            r_b       <= '0;
            r_sum     <= '0;
            r_idx_oh  <= '0;
            r_carry   <= 1'b0;
            r_s1      <= 1'b0;
            r_c1      <= 1'b0;
            r_result  <= '0;
            r_done    <= 1'b0;
        end else begin
            r_start_q <= uio_in[0];
            r_state   <= w_state_next;
            r_done    <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (w_start_pulse) begin
                        r_a      <= ui_in[3:0] & OpMask;
                        r_b      <= ui_in[7:4] & OpMask;
                        r_sum    <= '0;
                        r_carry  <= 1'b0;
                        r_idx_oh <= 4'b0001;
                    end
                end
                StHa1: begin
                    r_s1 <= w_ha_s;
                    r_c1 <= w_ha_c;
                end
                StHa2: begin
                    r_carry <= w_carry_new;
                    r_sum   <= w_sum_next;
                    if (w_last) begin
                        r_result <= w_result_next;
                        r_done   <= 1'b1;
                    end else begin
                        r_idx_oh <= r_idx_oh << 1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign w_busy   = (r_state != StIdle);
    assign w_phase  = (r_state == StHa2);
    assign uo_out   = {w_phase, r_done, w_busy, r_result};
    assign uio_out  = 8'h00;
    assign uio_oe   = 8'h00;
    assign w_unused = &{1'b0, ena, uio_in[7:1], ui_in};

endmodule

// File: tb/tb_tt_um_usman_serial_adder.sv
// Self-checking bench for the serial adder tile: a cycle-count reference model compared every
// cycle, plus directed operations with literal expected results.
module tb_tt_um_usman_serial_adder;

    localparam int W = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int checks   = 0;
    int failures = 0;

    tt_um_usman_serial_adder #(.WIDTH(W)) dut (
        .ui_in  (ui_in),
        .uo_out (uo_out),
        .uio_in (uio_in),
        .uio_out(uio_out),
        .uio_oe (uio_oe),
        .ena    (ena),
        .clk    (clk),
        .rst_n  (rst_n)
    );

    always #5 clk = ~clk;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endfunction

    // Reference model: an operation is 2*W busy cycles, then result = A + B with a done pulse.
    int         m_cnt   = 0;
    logic [3:0] m_a     = '0;
    logic [3:0] m_b     = '0;
    logic [4:0] m_res   = '0;
    logic       m_done  = 1'b0;
    logic       m_sq    = 1'b0;
    logic       m_valid = 1'b0;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_cnt   = 0;
            m_res   = '0;
            m_done  = 1'b0;
            m_sq    = 1'b0;
            m_valid = 1'b1;
        end else begin
            m_done = 1'b0;
            if (m_cnt > 0) begin
                m_cnt--;
                if (m_cnt == 0) begin
                    m_res  = 5'(m_a) + 5'(m_b);
                    m_done = 1'b1;
                end
            end else if (uio_in[0] && !m_sq) begin
                m_a   = ui_in[3:0];
                m_b   = ui_in[7:4];
                m_cnt = 2 * W;
            end
            m_sq = uio_in[0];
        end
    end

    // HA2 falls on the cycles where an odd number of busy cycles remain.
    always @(negedge clk) begin
        if (m_valid) begin
            chk("uo_out_model", uo_out,
                {(m_cnt > 0) && (m_cnt % 2 == 1), m_done, m_cnt > 0, m_res});
            chk("uio_out_zero", uio_out, 8'h00);
            chk("uio_oe_zero", uio_oe, 8'h00);
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic pulse_start(input logic [3:0] a, input logic [3:0] b);
        ui_in     = {b, a};
        uio_in[0] = 1'b1;
        cyc(1);
        uio_in[0] = 1'b0;
    endtask

    task automatic op(input logic [3:0] a, input logic [3:0] b, input logic [4:0] exp);
        int n;
        pulse_start(a, b);
        n = 0;
        while (uo_out[5] && n < 40) begin
            n++;
            cyc(1);
        end
        chk("busy_len", n, 2 * W);
        chk("done_pulse", uo_out[6], 1'b1);
        chk("result", uo_out[4:0], exp);
        cyc(1);
        chk("done_drop", uo_out[6], 1'b0);
        chk("result_hold", uo_out[4:0], exp);
    endtask

    initial begin
        int dones;
        int n;
        bit late_busy;
        rst_n  = 1'b0;
        ena    = 1'b1;
        ui_in  = 8'h00;
        uio_in = 8'h00;
        cyc(3);
        chk("reset_uo_out", uo_out, 8'h00);
        rst_n = 1'b1;
        cyc(1);

        op(4'd3, 4'd5, 5'h08);
        op(4'd15, 4'd1, 5'h10);
        op(4'd15, 4'd15, 5'h1E);
        op(4'd0, 4'd0, 5'h00);

        // Start held high: a single operation.
        ui_in     = 8'h22;
        uio_in[0] = 1'b1;
        dones     = 0;
        late_busy = 1'b0;
        for (int i = 0; i < 20; i++) begin
            cyc(1);
            if (uo_out[6]) dones++;
            if (i >= 8 && uo_out[5]) late_busy = 1'b1;
        end
        chk("held_done_count", dones, 1);
        chk("held_result", uo_out[4:0], 5'h04);
        chk("held_busy_after", late_busy, 1'b0);
        uio_in[0] = 1'b0;
        cyc(1);

        // Operand change and restart attempt while busy are ignored.
        pulse_start(4'd1, 4'd1);
        cyc(2);
        ui_in     = 8'hFF;
        uio_in[0] = 1'b1;
        cyc(1);
        uio_in[0] = 1'b0;
        n = 0;
        while (!uo_out[6] && n < 20) begin
            n++;
            cyc(1);
        end
        chk("busy_ign_done_seen", uo_out[6], 1'b1);
        chk("busy_ign_result", uo_out[4:0], 5'h02);
        cyc(10);
        chk("busy_ign_no_second", uo_out[5], 1'b0);

        // Reset mid-operation discards it.
        pulse_start(4'd7, 4'd9);
        cyc(4);
        rst_n = 1'b0;
        cyc(1);
        chk("midreset_uo_out", uo_out, 8'h00);
        rst_n = 1'b1;
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            cyc(1);
            if (uo_out[6]) dones++;
        end
        chk("midreset_no_done", dones, 0);
        op(4'd7, 4'd9, 5'h10);

        // Back-to-back; the model checks the old result holds while busy.
        op(4'd4, 4'd6, 5'h0A);

        // Random traffic including glitchy start, operand churn and occasional reset.
        for (int i = 0; i < 1500; i++) begin
            ui_in       = 8'($urandom);
            uio_in[7:1] = 7'($urandom);
            if ($urandom_range(0, 3) == 0) uio_in[0] = ~uio_in[0];
            rst_n = ($urandom_range(0, 99) != 0);
            cyc(1);
        end
        rst_n = 1'b1;
        cyc(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
